// File: rtl/dmem_mmio.sv
// Data memory stage for the single-cycle core: word RAM plus MMIO (TX FIFO, status, cycle counter).
// Define DMEM_MMIO_CYCLE_COUNTER_EN to build the CYCLE counter; otherwise CYCLE reads 0.
module dmem_mmio #(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RAW = $clog2(RAM_WORDS);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int CW  = FAW + 1;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CYCLE  = 2'd2;

  logic [31:0]    ram [RAM_WORDS];
  logic [31:0]    fifo_mem [FIFO_DEPTH];
  logic [FAW-1:0] rd_ptr;
  logic [FAW-1:0] wr_ptr;
  logic [CW-1:0]  count;
  logic           overflow;
  logic [31:0]    cycle_val;

  logic [RAW-1:0] ram_idx;
  logic           is_mmio;
  logic [1:0]     mmio_off;
  logic           full;
  logic           empty;
  logic           push_req;
  logic           push;
  logic           pop;
  logic           status_wr;
  logic [7:0]     count8;
  logic [31:0]    status;

  // Address bits outside the decoded fields alias by design.
  logic unused_addr;
  assign unused_addr = ^{ALUResult[30:RAW+2], ALUResult[1:0]};

  assign ram_idx   = ALUResult[RAW+1:2];
  assign is_mmio   = ALUResult[31];
  assign mmio_off  = ALUResult[3:2];

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign tx_valid  = !empty;
  assign tx_data   = fifo_mem[rd_ptr];

  assign push_req  = MemWrite && is_mmio && (mmio_off == OFF_TXDATA);
  assign push      = push_req && !full;
  assign pop       = tx_valid && tx_ready;
  assign status_wr = MemWrite && is_mmio && (mmio_off == OFF_STATUS);

  // RAM is not reset and keeps accepting writes while reset is asserted.
  always_ff @(posedge clk) begin
    if (MemWrite && !is_mmio) begin
      ram[ram_idx] <= WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_mem[wr_ptr] <= WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FAW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FAW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
      if (status_wr) begin
        overflow <= 1'b0;
      end else if (push_req && full) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef DMEM_MMIO_CYCLE_COUNTER_EN
  logic cycle_wr;
  assign cycle_wr = MemWrite && is_mmio && (mmio_off == OFF_CYCLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_val <= '0;
    end else if (cycle_wr) begin
      cycle_val <= WriteData;
    end else begin
      cycle_val <= cycle_val + 32'd1;
    end
  end
`else
  assign cycle_val = '0;
`endif

  assign count8 = 8'(count);

  always_comb begin
    status       = '0;
    status[0]    = full;
    status[1]    = empty;
    status[2]    = overflow;
    status[15:8] = count8;
  end

  always_comb begin
    ReadData = '0;
    if (!is_mmio) begin
      ReadData = ram[ram_idx];
    end else begin
      case (mmio_off)
        OFF_STATUS: ReadData = status;
        OFF_CYCLE:  ReadData = cycle_val;
        default:    ReadData = '0;
      endcase
    end
  end

endmodule
